rst_seq_sonata: RTL and testbench

//  Reset sequencer that consumes the system clock, the PLL lock and the board reset button.

---
 rtl/rst_seq_sonata.sv | 161 ++++++++++++++++
 tb/tb_rst_seq_sonata.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_sonata.sv
// Staged reset sequencer: synchronises PLL lock and the reset button, holds reset after lock,
// then releases NumStages active-low resets in order. Optional watchdog: RST_SEQ_WDOG_EN.
module rst_seq_sonata #(
    parameter int SysClkFreq     = 50_000_000,
    parameter int DebounceCycles = SysClkFreq / 1000,
    parameter int HoldCycles     = 1024,
    parameter int NumStages      = 3,
    parameter int StageGap       = 16,
    parameter int WdogCycles     = SysClkFreq
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_i,
    input  logic                 pll_locked_i,
    input  logic                 ext_rst_ni,
    input  logic                 sw_rst_req_i,
    input  logic                 wdog_kick_i,
    output logic [NumStages-1:0] rst_stage_no,
    output logic                 seq_done_o,
    output logic [1:0]           rst_cause_o,
    output logic [7:0]           lock_loss_cnt_o
);

    localparam int DB_W   = $clog2(DebounceCycles + 1);
    localparam int HOLD_W = $clog2(HoldCycles + 1);
    localparam int GAP_W  = $clog2(StageGap + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DebounceCycles - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HoldCycles - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(StageGap - 1);

    typedef enum logic [1:0] {S_WAIT_LOCK, S_HOLD, S_RELEASE, S_RUN} state_t;

    state_t                r_state;
    logic [1:0]            r_lock_sync;
    logic [1:0]            r_btn_sync;
    logic                  w_lock_s;
    logic                  w_btn_s;
    logic [DB_W-1:0]       r_db_cnt;
    logic                  r_db_armed;
    logic                  r_btn_press;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [NumStages-1:0]  w_stage_next;
    logic                  w_wdog_fire;

    assign w_lock_s     = r_lock_sync[1];
    assign w_btn_s      = r_btn_sync[1];
    assign w_stage_next = (rst_stage_no << 1) | NumStages'(1);

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_lock_sync <= '0;
            r_btn_sync  <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[0], pll_locked_i};
            r_btn_sync  <= {r_btn_sync[0], ext_rst_ni};
        end
    end

    // A press fires once per low run and re-arms only after the button is seen released.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_db_cnt    <= '0;
            r_db_armed  <= 1'b0;
            r_btn_press <= 1'b0;
        end else if (w_btn_s) begin
            r_db_cnt    <= '0;
            r_db_armed  <= 1'b1;
            r_btn_press <= 1'b0;
        end else if (r_db_armed && (r_db_cnt == DB_LAST)) begin
            r_db_armed  <= 1'b0;
            r_btn_press <= 1'b1;
        end else begin
            r_btn_press <= 1'b0;
            if (r_db_armed) r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WdogCycles + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WdogCycles - 1);
    logic [WD_W-1:0] r_wdog_cnt;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_wdog_cnt <= '0;
        end else if ((r_state != S_RUN) || wdog_kick_i) begin
            r_wdog_cnt <= '0;
        end else if (r_wdog_cnt != WD_LAST) begin
            r_wdog_cnt <= r_wdog_cnt + WD_W'(1);
        end
    end

    assign w_wdog_fire = (r_state == S_RUN) && !wdog_kick_i && (r_wdog_cnt == WD_LAST);
`else
    logic w_unused_wdog;
    assign w_unused_wdog = wdog_kick_i & (WdogCycles > 0);
    assign w_wdog_fire   = 1'b0;
`endif

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_state         <= S_WAIT_LOCK;
            rst_stage_no    <= '0;
            seq_done_o      <= 1'b0;
            rst_cause_o     <= 2'd0;
            lock_loss_cnt_o <= 8'd0;
            r_hold_cnt      <= '0;
            r_gap_cnt       <= '0;
        end else if (r_state == S_WAIT_LOCK) begin
            rst_stage_no <= '0;
            seq_done_o   <= 1'b0;
            if (w_lock_s) begin
                r_state    <= S_HOLD;
                r_hold_cnt <= '0;
            end
        end else if (!w_lock_s) begin
            r_state      <= S_WAIT_LOCK;
            rst_stage_no <= '0;
            seq_done_o   <= 1'b0;
            rst_cause_o  <= 2'd1;
            if (lock_loss_cnt_o != 8'hFF) lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
        end else if (w_wdog_fire || r_btn_press || sw_rst_req_i) begin
            r_state      <= S_HOLD;
            r_hold_cnt   <= '0;
            rst_stage_no <= '0;
            seq_done_o   <= 1'b0;
            rst_cause_o  <= w_wdog_fire ? 2'd3 : 2'd2;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        rst_stage_no <= NumStages'(1);
                        r_gap_cnt    <= '0;
                        if (NumStages == 1) begin
                            r_state    <= S_RUN;
                            seq_done_o <= 1'b1;
                        end else begin
                            r_state <= S_RELEASE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        rst_stage_no <= w_stage_next;
                        r_gap_cnt    <= '0;
                        if (&w_stage_next) begin
                            r_state    <= S_RUN;
                            seq_done_o <= 1'b1;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_sonata.sv
// Bench for rst_seq_sonata: directed scenarios plus randomized stimulus against a
// timestamp-based reference model. Define RST_SEQ_WDOG_EN to include the watchdog checks.
module tb_rst_seq_sonata;

    localparam int HOLD  = 16;
    localparam int GAP   = 4;
    localparam int DEB   = 8;
    localparam int NS    = 3;
    localparam int WDOG  = 100;
    localparam int RUNAT = HOLD + (NS - 1) * GAP;
    localparam int VW    = NS + 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll = 1'b0;
    logic          ext = 1'b1;
    logic          sw = 1'b0;
    logic          kick = 1'b0;
    logic [NS-1:0] rst_stage_no;
    logic          seq_done_o;
    logic [1:0]    rst_cause_o;
    logic [7:0]    lock_loss_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    rst_seq_sonata #(
        .SysClkFreq(1000), .DebounceCycles(DEB), .HoldCycles(HOLD),
        .NumStages(NS), .StageGap(GAP), .WdogCycles(WDOG)
    ) dut (
        .clk_sys_i(clk), .rst_sys_i(rst), .pll_locked_i(pll), .ext_rst_ni(ext),
        .sw_rst_req_i(sw), .wdog_kick_i(kick), .rst_stage_no(rst_stage_no),
        .seq_done_o(seq_done_o), .rst_cause_o(rst_cause_o), .lock_loss_cnt_o(lock_loss_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: sequencing is tracked as elapsed cycles since the last HOLD entry.
    bit         m_active = 1'b0;
    int         m_elapsed = 0;
    logic [1:0] m_cause = 2'd0;
    int         m_llc = 0;
    bit         m_lq0 = 1'b0, m_lq1 = 1'b0, m_bq0 = 1'b0, m_bq1 = 1'b0;
    int         m_low_run = -1;
    bit         m_press = 1'b0;
    int         m_now = 0;
    int         m_mark = 0;

    task automatic model_step();
        bit lk_s, bt_s, ev_btn, in_run, wd_fire;
        if (rst) begin
            m_active = 1'b0; m_elapsed = 0; m_cause = 2'd0; m_llc = 0;
            m_lq0 = 1'b0; m_lq1 = 1'b0; m_bq0 = 1'b0; m_bq1 = 1'b0;
            m_low_run = -1; m_press = 1'b0;
        end else begin
            lk_s = m_lq1; bt_s = m_bq1;
            m_lq1 = m_lq0; m_lq0 = pll; m_bq1 = m_bq0; m_bq0 = ext;
            ev_btn = m_press;
            if (bt_s) m_low_run = 0;
            else if (m_low_run >= 0) m_low_run++;
            m_press = (m_low_run == DEB);
            in_run = m_active && (m_elapsed >= RUNAT);
            wd_fire = 1'b0;
`ifdef RST_SEQ_WDOG_EN
            if (in_run && !kick && (m_now - m_mark == WDOG)) wd_fire = 1'b1;
`endif
            if (!m_active) begin
                if (lk_s) begin m_active = 1'b1; m_elapsed = 0; end
            end else if (!lk_s) begin
                m_active = 1'b0; m_cause = 2'd1;
                if (m_llc < 255) m_llc++;
            end else if (wd_fire) begin
                m_elapsed = 0; m_cause = 2'd3;
            end else if (ev_btn || sw) begin
                m_elapsed = 0; m_cause = 2'd2;
            end else if (m_elapsed < RUNAT) begin
                m_elapsed++;
            end
            if ((m_active && m_elapsed == RUNAT && !in_run) || kick) m_mark = m_now;
        end
        m_now++;
    endtask

    function automatic logic [VW-1:0] m_expect();
        logic [NS-1:0] s;
        logic          d;
        s = '0;
        for (int k = 0; k < NS; k++)
            if (m_active && m_elapsed >= HOLD + k * GAP) s[k] = 1'b1;
        d = m_active && (m_elapsed >= RUNAT);
        return {s, d, m_cause, m_llc[7:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (seq_done_o !== 1'b1 && n < limit) begin cyc(); n++; end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll = 1'b0; ext = 1'b1; sw = 1'b0; kick = 1'b0;
        repeat (3) cyc();
        n_tests++;
        if ({rst_stage_no, seq_done_o, rst_cause_o, lock_loss_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=0", {rst_stage_no, seq_done_o, rst_cause_o, lock_loss_cnt_o});
        end
    endtask

    task automatic test_power_up();
        int t0 = -1, t1 = -1, t2 = -1, td = -1;
        logic [NS-1:0] at20 = '0, at24 = '0;
        pll = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (t0 < 0 && rst_stage_no[0]) t0 = i;
            if (t1 < 0 && rst_stage_no[1]) t1 = i;
            if (t2 < 0 && rst_stage_no[2]) t2 = i;
            if (td < 0 && seq_done_o) td = i;
            if (i == 20) at20 = rst_stage_no;
            if (i == 24) at24 = rst_stage_no;
        end
        n_tests++;
        if (t0 != 18 || t1 != 22 || t2 != 26 || td != 26) begin
            n_fail++;
            $display("FAIL pwr_timing got=%0d/%0d/%0d/%0d exp=18/22/26/26", t0, t1, t2, td);
        end
        n_tests++;
        if (at20 !== 3'b001 || at24 !== 3'b011) begin
            n_fail++;
            $display("FAIL pwr_order got=%b,%b exp=001,011", at20, at24);
        end
        n_tests++;
        if (rst_cause_o !== 2'd0 || rst_stage_no !== 3'b111) begin
            n_fail++;
            $display("FAIL pwr_final got=%0d,%b exp=0,111", rst_cause_o, rst_stage_no);
        end
    endtask

    task automatic test_lock_loss();
        int k = 1, n;
        pll = 1'b0; cyc(); pll = 1'b1;
        while (rst_stage_no !== '0 && k < 6) begin cyc(); k++; end
        n_tests++;
        if (k != 3 || rst_cause_o !== 2'd1 || lock_loss_cnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL lock_loss got=%0d,%0d,%0d exp=3,1,1", k, rst_cause_o, lock_loss_cnt_o);
        end
        wait_done(100, n);
        n_tests++;
        if (n != 25) begin
            n_fail++;
            $display("FAIL lock_reseq got=%0d exp=25", n);
        end
    endtask

    task automatic test_button();
        int drops = 0;
        logic prev;
        prev = seq_done_o;
        for (int i = 0; i < 30; i++) begin
            ext = (i >= 5);
            cyc();
            if (prev && !seq_done_o) drops++;
            prev = seq_done_o;
        end
        n_tests++;
        if (drops != 0 || rst_cause_o !== 2'd1 || seq_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL btn_glitch got=%0d,%0d exp=0,1", drops, rst_cause_o);
        end
        for (int i = 0; i < 80; i++) begin
            ext = !((i < 5) || (i >= 6 && i < 14));
            cyc();
            if (prev && !seq_done_o) drops++;
            prev = seq_done_o;
        end
        n_tests++;
        if (drops != 1 || rst_cause_o !== 2'd2 || seq_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL btn_bounce got=%0d,%0d,%0d exp=1,2,1", drops, rst_cause_o, seq_done_o);
        end
    endtask

    task automatic test_sw_release();
        int k = 0, n;
        sw = 1'b1; cyc(); sw = 1'b0;
        while (rst_stage_no !== 3'b001 && k < 40) begin cyc(); k++; end
        sw = 1'b1; cyc(); sw = 1'b0;
        n_tests++;
        if (rst_stage_no !== '0 || rst_cause_o !== 2'd2 || seq_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_release got=%b,%0d exp=000,2", rst_stage_no, rst_cause_o);
        end
        k = 0;
        while (!rst_stage_no[0] && k < 40) begin cyc(); k++; end
        n_tests++;
        if (k != HOLD) begin
            n_fail++;
            $display("FAIL sw_hold_restart got=%0d exp=%0d", k, HOLD);
        end
        wait_done(100, n);
        pll = 1'b0; cyc(); pll = 1'b1; cyc();
        sw = 1'b1; cyc(); sw = 1'b0;
        n_tests++;
        if (rst_cause_o !== 2'd1 || lock_loss_cnt_o !== 8'd2 || rst_stage_no !== '0) begin
            n_fail++;
            $display("FAIL sw_vs_lock got=%0d,%0d,%b exp=1,2,000", rst_cause_o, lock_loss_cnt_o, rst_stage_no);
        end
        wait_done(100, n);
    endtask

    task automatic test_saturation();
        int n;
        for (int i = 0; i < 300; i++) begin
            pll = 1'b0; cyc(); pll = 1'b1;
            repeat (5) cyc();
        end
        n_tests++;
        if (lock_loss_cnt_o !== 8'd255) begin
            n_fail++;
            $display("FAIL llc_saturate got=%0d exp=255", lock_loss_cnt_o);
        end
        rst = 1'b1; cyc(); cyc();
        n_tests++;
        if (lock_loss_cnt_o !== 8'd0 || rst_cause_o !== 2'd0 || rst_stage_no !== '0) begin
            n_fail++;
            $display("FAIL llc_clear got=%0d,%0d,%b exp=0,0,000", lock_loss_cnt_o, rst_cause_o, rst_stage_no);
        end
        rst = 1'b0;
        wait_done(60, n);
        n_tests++;
        if (n != 27) begin
            n_fail++;
            $display("FAIL post_rst_seq got=%0d exp=27", n);
        end
    endtask

    task automatic test_wdog();
        int k = 0, n, drops = 0;
        sw = 1'b1; cyc(); sw = 1'b0;
        wait_done(100, n);
`ifdef RST_SEQ_WDOG_EN
        while (rst_stage_no !== '0 && k < 200) begin cyc(); k++; end
        n_tests++;
        if (k != WDOG || rst_cause_o !== 2'd3) begin
            n_fail++;
            $display("FAIL wdog_timeout got=%0d,%0d exp=%0d,3", k, rst_cause_o, WDOG);
        end
        wait_done(100, n);
`endif
        for (int i = 0; i < 400; i++) begin
            kick = (i % 50 == 0);
            cyc();
            kick = 1'b0;
            if (seq_done_o !== 1'b1) drops++;
        end
        n_tests++;
        if (drops != 0 || rst_cause_o === 2'd3) begin
            n_fail++;
            $display("FAIL wdog_kicked got=%0d,%0d exp=0,!3", drops, rst_cause_o);
        end
    endtask

    task automatic test_random();
        int pl_left = 0, lo_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (pl_left == 0 && $urandom_range(0, 299) == 0) pl_left = $urandom_range(1, 3);
            pll = (pl_left == 0);
            if (pl_left > 0) pl_left--;
            if (lo_left == 0 && $urandom_range(0, 59) == 0) lo_left = $urandom_range(1, 14);
            ext = (lo_left == 0);
            if (lo_left > 0) lo_left--;
            sw   = ($urandom_range(0, 199) == 0);
            kick = ($urandom_range(0, 39) == 0);
            cyc();
            n_tests++;
            if ({rst_stage_no, seq_done_o, rst_cause_o, lock_loss_cnt_o} !== m_expect()) begin
                n_fail++;
                $display("FAIL rand_cmp cyc=%0d got=%h exp=%h", c,
                         {rst_stage_no, seq_done_o, rst_cause_o, lock_loss_cnt_o}, m_expect());
            end
        end
        pll = 1'b1; ext = 1'b1; sw = 1'b0; kick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss();
        test_button();
        test_sw_release();
        test_saturation();
        test_wdog();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
